alu_serial_ctrl: RTL and testbench
==================================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with the ports listed below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  operation request; sampled only in IDLE.
REQ-005 abort  in  1  synchronous cancel of the running operation.
REQ-006 op  in  3  operation code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all other codes are invalid.
REQ-007 a, b  in  32 each  operands, latched when start is accepted.
REQ-008 busy  out  1  high in the RUN and DONE states.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 result  out  32  result; held until the next accepted start.
REQ-011 zero  out  1  high when result equals 0; valid with done and held with result.
REQ-012 invalid_op  out  1  high when the latched op is invalid; valid with done and held.
REQ-013 ovf  out  1  signed overflow flag; see Configuration.
REQ-014 slice_ai, slice_bi, slice_lessi, slice_ci  out  1 each  operand, less and carry-in drive to the external 1-bit ALU slice.
REQ-015 slice_aluop  out  3  slice operation select, bit 2 = b-invert.
REQ-016 slice_c1, slice_ri  in  1 each  combinational carry-out and result returned by the slice in the same cycle.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE after bit 31.
- DONE -> IDLE unconditionally.
REQ-018 On accepting start, the block SHALL latch a, b and op and clear the 5-bit bit counter to 0.
REQ-019 In RUN, cycle k (k = 0..31) SHALL process bit k:
- slice_ai = a[k]; slice_bi = b[k].
- slice_lessi = 0.
- slice_ci = carry register.
- slice_ri is captured into result bit k on the clock edge.
- slice_c1 is captured into the carry register on the clock edge.
REQ-020 Carry register initial value SHALL be 1 for SUB and SLT, and 0 for all other ops.
REQ-021 slice_aluop SHALL equal the latched op, except for SLT, where it is 110 (SUB pass).
REQ-022 For SLT, the DONE state SHALL replace the result with {31'b0, s31 XOR v}:
- s31 = captured bit-31 sum.
- v = carry-in to bit 31 XOR carry-out of bit 31.
REQ-023 For invalid op codes, the slice SHALL be driven with 000, and at DONE result = 0, zero = 1, invalid_op = 1.
REQ-024 Latency SHALL be fixed: start accepted at cycle 0, bits processed in cycles 1..32, done=1 in cycle 33, IDLE in cycle 34; a new start is accepted in cycle 34.
REQ-025 start while busy=1 SHALL be ignored; there is no queuing.
REQ-026 abort=1 in RUN SHALL force IDLE on the next edge:
- no done pulse is produced;
- result, zero, ovf and invalid_op are not updated;
- abort in IDLE or DONE has no effect.
REQ-027 Simultaneous abort and start in the same IDLE cycle SHALL accept start.
REQ-028 The bit counter SHALL not wrap: reaching 31 in RUN forces DONE.
REQ-029 When busy=0, the slice outputs SHALL be driven to 0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force the following, including mid-operation:
- FSM = IDLE;
- counter, carry register and all latched operands = 0;
- busy = 0, done = 0;
- result = 0, zero = 1, ovf = 0, invalid_op = 0;
- all slice outputs = 0.
REQ-031 After reset deassertion, the first start SHALL be accepted at the first rising edge with start=1.

Configuration
REQ-032 Macro ALU_OVF_DETECT_EN controls overflow detection.
- Defined: at DONE, ovf = carry-in(bit 31) XOR carry-out(bit 31) for ADD and SUB, 0 for all other ops; ovf is held with result.
- Undefined: ovf is tied to 0 and no overflow logic is synthesized.
- SLT behaviour is identical in both builds.

Verification
REQ-033 The bench SHALL model the slice behaviourally and cover at least these directed scenarios:
- ADD a=0x7FFFFFFF, b=1 -> done in cycle 33, result=0x80000000, zero=0, ovf=1 (0 when the macro is undefined).
- SUB a=5, b=5 -> result=0, zero=1, ovf=0; SUB a=3, b=5 -> result=0xFFFFFFFE.
- SLT a=0x80000000, b=1 -> result=1; SLT a=1, b=0x80000000 -> result=0; AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000.
- abort asserted in cycle 10 of an ADD -> IDLE next cycle, no done, result keeps its prior value; start pulsed during RUN -> ignored.
- rst_n low at cycle 20 of a SUB -> immediate IDLE, result=0, zero=1; op=101 -> result=0, invalid_op=1.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial 32-bit ALU controller driving an external combinational 1-bit ALU slice.
// Latency: start accepted in cycle 0, bits 0..31 in cycles 1..32, done pulse in cycle 33, idle in cycle 34.
// Backpressure: none; start is ignored while busy, abort cancels a running operation without a done pulse.
// Build option: define ALU_OVF_DETECT_EN to enable signed-overflow detection on ovf (tied low otherwise).

module alu_serial_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        invalid_op,
    output logic        ovf,
    output logic        slice_ai,
    output logic        slice_bi,
    output logic        slice_lessi,
    output logic        slice_ci,
    output logic [2:0]  slice_aluop,
    input  logic        slice_c1,
    input  logic        slice_ri
);

    // FSM encoding; the fourth code is unreachable and decodes back to IDLE.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    // Operation codes; anything not listed here is treated as invalid.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [4:0] LAST_BIT = 5'd31;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [4:0]  cnt;
    logic        carry;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    // Bits 0..30 of the slice result, shifted in from the top so bit 0 lands at position 0.
    logic [30:0] acc;

    logic        accept;
    logic        in_run;
    logic        at_last;
    logic        finish;
    logic        op_valid;
    logic        is_slt;
    logic        v31;
    logic [31:0] final_word;

    // Returns 1 when the code names one of the five supported operations.
    function automatic logic valid_code(input logic [2:0] code);
        return (code == OP_AND) || (code == OP_OR) || (code == OP_ADD) ||
               (code == OP_SUB) || (code == OP_SLT);
    endfunction

    assign accept   = (state == S_IDLE) && start;
    assign in_run   = (state == S_RUN);
    assign at_last  = in_run && (cnt == LAST_BIT);
    // The operation completes only if the last bit is processed without a concurrent abort.
    assign finish   = at_last && !abort;
    assign op_valid = valid_code(op_q);
    assign is_slt   = (op_q == OP_SLT);

    assign busy = (state == S_RUN) || (state == S_DONE);
    assign done = (state == S_DONE);
    assign zero = (result == 32'd0);

    // Next-state logic: abort wins over completion, DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (cnt == LAST_BIT) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch on accept, then per-bit counter, carry chain and partial-result capture while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= 3'd0;
            cnt   <= 5'd0;
            carry <= 1'b0;
            acc   <= 31'd0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt   <= 5'd0;
            // Subtraction (and SLT, which runs as a subtraction) needs the +1 of two's complement.
            carry <= (op == OP_SUB) || (op == OP_SLT);
        end else if (in_run && !abort) begin
            carry <= slice_c1;
            // Counter saturates at 31; the FSM leaves RUN on that bit so it never wraps.
            if (cnt != LAST_BIT) begin
                cnt <= cnt + 5'd1;
                acc <= {slice_ri, acc[30:1]};
            end
        end
    end

    // Signed overflow of the bit-31 stage: carry into the top bit differs from carry out of it.
    assign v31 = carry ^ slice_c1;

    // Final result word, formed in the last RUN cycle so it is already valid while done is high.
    always_comb begin
        final_word = {slice_ri, acc};
        if (!op_valid) begin
            final_word = 32'd0;
        end else if (is_slt) begin
            // Sign of (a - b) corrected for overflow gives the signed less-than.
            final_word = {31'd0, slice_ri ^ v31};
        end
    end

    // Architectural result and status: updated only on a completed operation, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= 32'd0;
            invalid_op <= 1'b0;
        end else if (finish) begin
            result     <= final_word;
            invalid_op <= !op_valid;
        end
    end

`ifdef ALU_OVF_DETECT_EN
    logic ovf_q;
    logic is_arith;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // Overflow flag for ADD/SUB only, captured and held alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (finish) begin
            ovf_q <= is_arith && v31;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Slice drive: active only in RUN, all zero otherwise; invalid ops run the slice as a harmless AND.
    always_comb begin
        slice_ai    = 1'b0;
        slice_bi    = 1'b0;
        slice_ci    = 1'b0;
        slice_aluop = 3'b000;
        if (in_run) begin
            slice_ai = a_q[cnt];
            slice_bi = b_q[cnt];
            slice_ci = carry;
            if (!op_valid) begin
                slice_aluop = 3'b000;
            end else if (is_slt) begin
                slice_aluop = OP_SUB;
            end else begin
                slice_aluop = op_q;
            end
        end
    end

    // The less input of the slice is unused by this controller.
    assign slice_lessi = 1'b0;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        invalid_op;
    logic        ovf;
    logic        slice_ai;
    logic        slice_bi;
    logic        slice_lessi;
    logic        slice_ci;
    logic [2:0]  slice_aluop;
    logic        slice_c1;
    logic        slice_ri;

    int n_checks = 0;
    int n_pass   = 0;

    alu_serial_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .invalid_op  (invalid_op),
        .ovf         (ovf),
        .slice_ai    (slice_ai),
        .slice_bi    (slice_bi),
        .slice_lessi (slice_lessi),
        .slice_ci    (slice_ci),
        .slice_aluop (slice_aluop),
        .slice_c1    (slice_c1),
        .slice_ri    (slice_ri)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice: bit 2 of aluop inverts b, low bits pick AND/OR/ADD/LESS.
    logic slice_bb;
    always_comb begin
        slice_bb = slice_bi ^ slice_aluop[2];
        slice_c1 = (slice_ai & slice_bb) | (slice_ai & slice_ci) | (slice_bb & slice_ci);
        case (slice_aluop[1:0])
            2'b00:   slice_ri = slice_ai & slice_bb;
            2'b01:   slice_ri = slice_ai | slice_bb;
            2'b10:   slice_ri = slice_ai ^ slice_bb ^ slice_ci;
            default: slice_ri = slice_lessi;
        endcase
    end

    // Word-level reference model.
    function automatic logic is_valid(input logic [2:0] o);
        return (o == 3'b000) || (o == 3'b001) || (o == 3'b010) || (o == 3'b110) || (o == 3'b111);
    endfunction

    function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_ovf(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
`ifdef ALU_OVF_DETECT_EN
        if (o == 3'b010) begin
            r = x + y;
            return (x[31] == y[31]) && (r[31] != x[31]);
        end
        if (o == 3'b110) begin
            r = x - y;
            return (x[31] != y[31]) && (r[31] != x[31]);
        end
`endif
        r = 32'd0;
        return r[0];
    endfunction

    function automatic logic [2:0] model_aluop(input logic [2:0] o);
        if (!is_valid(o)) return 3'b000;
        if (o == 3'b111) return 3'b110;
        return o;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        repeat (3) tick();
        n_checks++;
        if ({busy, done, zero, invalid_op, ovf} !== 5'b00100) $display("FAIL reset_flags: got busy/done/zero/inv/ovf=%b want 00100", {busy, done, zero, invalid_op, ovf});
        else n_pass++;
        n_checks++;
        if (result !== 32'd0) $display("FAIL reset_result: got %h want 00000000", result);
        else n_pass++;
        n_checks++;
        if ({slice_ai, slice_bi, slice_lessi, slice_ci, slice_aluop} !== 7'd0) $display("FAIL reset_slice: got %b want 0000000", {slice_ai, slice_bi, slice_lessi, slice_ci, slice_aluop});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one complete operation and checks latency, slice drive, result and status flags.
    task automatic test_op_case(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        logic [31:0] er;
        er = model_result(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        n_checks++;
        if (busy !== 1'b1 || slice_aluop !== model_aluop(o) || slice_ai !== x[0] || slice_bi !== y[0])
            $display("FAIL %s run_start: got busy=%b aluop=%b ai=%b bi=%b want 1 %b %b %b", name, busy, slice_aluop, slice_ai, slice_bi, model_aluop(o), x[0], y[0]);
        else n_pass++;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat != 33) $display("FAIL %s latency: got %0d want 33", name, lat);
        else n_pass++;
        n_checks++;
        if (result !== er) $display("FAIL %s result: got %h want %h", name, result, er);
        else n_pass++;
        n_checks++;
        if (zero !== (er == 32'd0) || invalid_op !== !is_valid(o) || ovf !== model_ovf(o, x, y))
            $display("FAIL %s flags: got zero/inv/ovf=%b%b%b want %b%b%b", name, zero, invalid_op, ovf, er == 32'd0, !is_valid(o), model_ovf(o, x, y));
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== er)
            $display("FAIL %s idle_hold: got busy=%b done=%b result=%h want 0 0 %h", name, busy, done, result, er);
        else n_pass++;
    endtask

    task automatic test_directed;
        test_op_case("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        test_op_case("sub_eq", 3'b110, 32'd5, 32'd5);
        test_op_case("sub_neg", 3'b110, 32'd3, 32'd5);
        test_op_case("slt_true", 3'b111, 32'h8000_0000, 32'h0000_0001);
        test_op_case("slt_false", 3'b111, 32'h0000_0001, 32'h8000_0000);
        test_op_case("and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        test_op_case("or", 3'b001, 32'h0F00_0001, 32'h00F0_8000);
        test_op_case("invalid", 3'b101, 32'h1234_5678, 32'h9ABC_DEF0);
    endtask

    task automatic test_abort;
        logic [31:0] prior;
        int pulses;
        test_op_case("abort_prep", 3'b001, 32'hA5A5_0000, 32'h0000_5A5A);
        prior = 32'hA5A5_5A5A;
        start = 1'b1; op = 3'b010; a = 32'h1111_1111; b = 32'h2222_2222;
        tick();
        start = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        n_checks++;
        if (pulses != 0) $display("FAIL abort_no_done: got %0d done pulses want 0", pulses);
        else n_pass++;
        n_checks++;
        if (result !== prior || zero !== 1'b0 || invalid_op !== 1'b0) $display("FAIL abort_hold: got result=%h zero=%b inv=%b want %h 0 0", result, zero, invalid_op, prior);
        else n_pass++;
    endtask

    task automatic test_start_ignored;
        int lat;
        start = 1'b1; op = 3'b010; a = 32'h0001_0000; b = 32'h0000_00FF;
        tick();
        start = 1'b0;
        lat = 1;
        repeat (4) begin tick(); lat++; end
        start = 1'b1; op = 3'b000; a = 32'hFFFF_FFFF; b = 32'h0000_0000;
        tick(); lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        n_checks++;
        if (lat != 33) $display("FAIL ignore_latency: got %0d want 33", lat);
        else n_pass++;
        n_checks++;
        if (result !== 32'h0001_00FF) $display("FAIL ignore_result: got %h want 000100ff", result);
        else n_pass++;
        tick();
    endtask

    task automatic test_abort_start_and_done;
        int lat;
        logic [31:0] er;
        er = model_result(3'b110, 32'd100, 32'd42);
        start = 1'b1; abort = 1'b1; op = 3'b110; a = 32'd100; b = 32'd42;
        tick();
        start = 1'b0; abort = 1'b0;
        lat = 1;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL abort_start_accept: got busy=%b want 1", busy);
        else n_pass++;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        n_checks++;
        if (lat != 33 || result !== er) $display("FAIL abort_start_result: got lat=%0d result=%h want 33 %h", lat, result, er);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || result !== er) $display("FAIL abort_in_done: got busy=%b result=%h want 0 %h", busy, result, er);
        else n_pass++;
    endtask

    task automatic test_reset_midop;
        start = 1'b1; op = 3'b110; a = 32'd9; b = 32'd2;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || ovf !== 1'b0 || invalid_op !== 1'b0)
            $display("FAIL midop_reset: got busy=%b done=%b result=%h zero=%b ovf=%b inv=%b want 0 0 00000000 1 0 0", busy, done, result, zero, ovf, invalid_op);
        else n_pass++;
        n_checks++;
        if ({slice_ai, slice_bi, slice_lessi, slice_ci, slice_aluop} !== 7'd0) $display("FAIL midop_reset_slice: got %b want 0000000", {slice_ai, slice_bi, slice_lessi, slice_ci, slice_aluop});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        test_op_case("after_reset", 3'b110, 32'd9, 32'd2);
    endtask

    task automatic test_random;
        logic [2:0] o;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0] ops [5];
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) o = 3'($urandom);
            else o = ops[$urandom_range(0, 4)];
            x = $urandom;
            y = $urandom;
            if (i % 6 == 0) y = x;
            if (i % 8 == 1) x = 32'h8000_0000;
            test_op_case("random", o, x, y);
        end
    endtask

    task automatic test_back_to_back;
        int t;
        int first;
        int second;
        first = -1; second = -1;
        start = 1'b1; op = 3'b010; a = 32'd7; b = 32'd8;
        t = 0;
        while (second < 0 && t < 100) begin
            tick();
            t++;
            if (done === 1'b1) begin
                if (first < 0) first = t;
                else second = t;
            end
        end
        start = 1'b0;
        n_checks++;
        if (first != 33 || second != 67) $display("FAIL back_to_back: got done at %0d and %0d want 33 and 67", first, second);
        else n_pass++;
        n_checks++;
        if (result !== 32'd15) $display("FAIL back_to_back_result: got %h want 0000000f", result);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_start_ignored();
        test_abort_start_and_done();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
